edid_ddc_responder: RTL and testbench

DDC/E-DDC I2C target that serves EDID bytes to an HDMI source. Decodes SCL/SDA from the connector, answers device 0x50 (EDID) and 0x30 (segment pointer), and fetches bytes from the EDID RAM's read port. The RAM's write side is loaded elsewhere; this block only reads.

---
 rtl/edid_pkg.sv | 25 ++
 rtl/ddc_line_filter.sv | 39 +++
 rtl/edid_ddc_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_edid_ddc_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edid_pkg.sv
// Shared types and constants for the EDID DDC responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package edid_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_OFS_BYTE,
    ST_OFS_ACK,
    ST_SEG_BYTE,
    ST_SEG_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } ddc_state_e;

  localparam logic [6:0] EDID_DEV_DEFAULT = 7'h50;
  localparam logic [6:0] SEG_DEV_DEFAULT  = 7'h30;

  localparam int RAM_AW = 15;
  localparam int RAM_DW = 8;

endpackage

// File: rtl/ddc_line_filter.sv
// Synchronizes one raw DDC line and suppresses pulses shorter than FILTER_LEN samples.
// Latency: 2 sync flops plus FILTER_LEN stable samples before the filtered level moves.
// Backpressure: none; free-running on every clk.
module ddc_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; resets to the idle (high) bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], raw};
  end

  // Count consecutive samples that disagree with the filtered level; flip once enough agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (sync[1] == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      filt <= sync[1];
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/edid_ddc_responder.sv
// DDC/E-DDC I2C target serving EDID bytes (dev 0x50) with segment pointer (dev 0x30).
// Latency: pin-to-decision 2+FILTER_LEN+1 clk; RAM read fetched one byte ahead of the bus.
// Backpressure: none; never stretches SCL, relies on clk being much faster than SCL.
module edid_ddc_responder
  import edid_pkg::*;
#(
  parameter int         FILTER_LEN = 3,
  parameter logic [6:0] EDID_DEV   = EDID_DEV_DEFAULT,
  parameter logic [6:0] SEG_DEV    = SEG_DEV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [RAM_AW-1:0] raddr,
  input  logic [RAM_DW-1:0] rdata,
  output logic              active
);

  logic scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  ddc_state_e state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] offset, offset_n;
  logic [6:0] segment, segment_n;
  logic       sda_oe_n, active_n;
  logic       ofs_got, ofs_got_n;
  logic       mack, mack_n;
  logic       byte_done, addr_match;

  ddc_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .raw(scl_in), .filt(scl_f)
  );

  ddc_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .raw(sda_in), .filt(sda_f)
  );

  // Previous filtered levels for edge and START/STOP detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);
  // Segment pointer is write-only; a read to it is not acknowledged.
  assign addr_match = (shreg[7:1] == EDID_DEV) || ((shreg[7:1] == SEG_DEV) && !shreg[0]);

  // Protocol state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      offset  <= '0;
      segment <= '0;
      sda_oe  <= 1'b0;
      active  <= 1'b0;
      ofs_got <= 1'b0;
      mack    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      offset  <= offset_n;
      segment <= segment_n;
      sda_oe  <= sda_oe_n;
      active  <= active_n;
      ofs_got <= ofs_got_n;
      mack    <= mack_n;
    end
  end

  // RAM address follows the pointer one clk later, well before the next byte load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) raddr <= '0;
    else        raddr <= {segment, offset};
  end

  // Next-state logic: STOP and START override everything, otherwise bit-level sequencing.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    offset_n  = offset;
    segment_n = segment;
    sda_oe_n  = sda_oe;
    active_n  = active;
    ofs_got_n = ofs_got;
    mack_n    = mack;

    if (stop_det) begin
      state_n   = ST_IDLE;
      sda_oe_n  = 1'b0;
      active_n  = 1'b0;
      segment_n = '0;
    end else if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_f};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (byte_done) begin
            bit_cnt_n = '0;
            if (addr_match) begin
              sda_oe_n = 1'b1;
              active_n = 1'b1;
              state_n  = ST_ADDR_ACK;
            end else begin
              active_n = 1'b0;
              state_n  = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (shreg[7:1] != EDID_DEV) begin
              state_n = ST_SEG_BYTE;
            end else if (shreg[0]) begin
              // First read byte: load from RAM and put its MSB on the bus.
              shreg_n  = rdata;
              offset_n = offset + 8'd1;
              sda_oe_n = ~rdata[7];
              state_n  = ST_RD_BYTE;
            end else begin
              ofs_got_n = 1'b0;
              state_n   = ST_OFS_BYTE;
            end
          end
        end
        ST_OFS_BYTE: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_f};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (byte_done) begin
            bit_cnt_n = '0;
            sda_oe_n  = 1'b1;
            state_n   = ST_OFS_ACK;
            // Only the first written byte is the offset; later ones are discarded.
            if (!ofs_got) begin
              offset_n  = shreg;
              ofs_got_n = 1'b1;
            end
          end
        end
        ST_OFS_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = ST_OFS_BYTE;
          end
        end
        ST_SEG_BYTE: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_f};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (byte_done) begin
            bit_cnt_n = '0;
            segment_n = shreg[6:0];
            sda_oe_n  = 1'b1;
            state_n   = ST_SEG_ACK;
          end
        end
        ST_SEG_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = ST_WAIT_STOP;
          end
        end
        ST_RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              sda_oe_n  = 1'b0;
              mack_n    = 1'b0;
              state_n   = ST_RD_ACK;
            end else begin
              bit_cnt_n = bit_cnt + 4'd1;
              shreg_n   = {shreg[6:0], 1'b0};
              sda_oe_n  = ~shreg[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            mack_n = ~sda_f;
          end else if (scl_fall) begin
            if (mack) begin
              shreg_n   = rdata;
              offset_n  = offset + 8'd1;
              sda_oe_n  = ~rdata[7];
              bit_cnt_n = '0;
              state_n   = ST_RD_BYTE;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
        end
        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edid_ddc_responder.sv
module tb_edid_ddc_responder;

  localparam time Q = 120;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe;
  logic        active;
  logic [14:0] raddr;
  logic [7:0]  rdata = 8'h00;

  int checks = 0;
  int failures = 0;

  logic watch = 1'b0;
  logic bad_seen = 1'b0;

  assign sda_bus = sda_m & ~sda_oe;

  edid_ddc_responder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl_in (scl_m),
    .sda_in (sda_bus),
    .sda_oe (sda_oe),
    .raddr  (raddr),
    .rdata  (rdata),
    .active (active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [14:0] a);
    return (a[7:0] ^ 8'hA5) + {a[14:8], 1'b0};
  endfunction

  always @(posedge clk) rdata <= mem_f(raddr);

  always @(posedge clk) if (watch && (sda_oe || active)) bad_seen <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic wbit(input logic b, input logic glitch);
    sda_m = b; #Q;
    scl_m = 1'b1;
    if (glitch) begin
      #(Q / 2); scl_m = 1'b0; #8; scl_m = 1'b1; #(Q + Q / 2 - 8);
    end else begin
      #(2 * Q);
    end
    scl_m = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    b = sda_bus;  #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(d[i], (7 - i) == glitch_bit);
    rbit(b);
    ack = ~b;
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~ack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [2:0] part;
    logic       b;

    #2;
    #50;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_active", active, 0);
    rst_n = 1'b1;
    #(2 * Q);

    // Basic read from offset 0
    i2c_start();
    wbyte(8'hA0, -1, ack); chk("basic_ack_dev_w", ack, 1);
    chk("basic_active", active, 1);
    wbyte(8'h00, -1, ack); chk("basic_ack_ofs", ack, 1);
    chk("basic_raddr0", raddr, 15'h0000);
    i2c_start();
    wbyte(8'hA1, -1, ack); chk("basic_ack_dev_r", ack, 1);
    rbyte(d, 1'b1); chk("basic_d0", d, 8'hA5);
    rbyte(d, 1'b1); chk("basic_d1", d, 8'hA4);
    rbyte(d, 1'b1); chk("basic_d2", d, 8'hA7);
    rbyte(d, 1'b0); chk("basic_d3", d, 8'hA6);
    #Q;
    chk("basic_sda_rel", sda_oe, 0);
    chk("basic_raddr4", raddr, 15'h0004);
    i2c_stop();
    #(2 * Q);
    chk("basic_active_off", active, 0);

    // Segmented read: segment 1, offset 0x80
    i2c_start();
    wbyte(8'h60, -1, ack); chk("seg_ack_dev", ack, 1);
    wbyte(8'h01, -1, ack); chk("seg_ack_val", ack, 1);
    i2c_start();
    wbyte(8'hA0, -1, ack); chk("seg_ack_w", ack, 1);
    wbyte(8'h80, -1, ack); chk("seg_ack_ofs", ack, 1);
    i2c_start();
    wbyte(8'hA1, -1, ack); chk("seg_ack_r", ack, 1);
    rbyte(d, 1'b1); chk("seg_d0", d, 8'h27);
    rbyte(d, 1'b0); chk("seg_d1", d, 8'h26);
    #Q;
    chk("seg_raddr", raddr, 15'h0182);
    i2c_stop();
    #(2 * Q);
    chk("seg_cleared", raddr[14:8], 0);

    // Offset wrap in segment 0
    i2c_start();
    wbyte(8'hA0, -1, ack);
    wbyte(8'hFE, -1, ack); chk("wrap_ack_ofs", ack, 1);
    i2c_start();
    wbyte(8'hA1, -1, ack);
    rbyte(d, 1'b1); chk("wrap_d0", d, 8'h5B);
    rbyte(d, 1'b1); chk("wrap_d1", d, 8'h5A);
    rbyte(d, 1'b0); chk("wrap_d2", d, 8'hA5);
    #Q;
    chk("wrap_raddr", raddr, 15'h0001);
    i2c_stop();

    // Offset wrap in segment 2 keeps the segment
    i2c_start();
    wbyte(8'h60, -1, ack);
    wbyte(8'h02, -1, ack);
    i2c_start();
    wbyte(8'hA0, -1, ack);
    wbyte(8'hFE, -1, ack);
    i2c_start();
    wbyte(8'hA1, -1, ack);
    rbyte(d, 1'b1); chk("wrap2_d0", d, 8'h5F);
    rbyte(d, 1'b1); chk("wrap2_d1", d, 8'h5E);
    rbyte(d, 1'b0); chk("wrap2_d2", d, 8'hA9);
    #Q;
    chk("wrap2_raddr", raddr, 15'h0201);
    i2c_stop();
    #(2 * Q);

    // Address reject: 0x51 write and 0x30 read
    watch = 1'b1;
    i2c_start();
    wbyte(8'hA2, -1, ack); chk("rej_51_ack", ack, 0);
    wbyte(8'h55, -1, ack); chk("rej_51_data_ack", ack, 0);
    i2c_stop();
    i2c_start();
    wbyte(8'h61, -1, ack); chk("rej_30r_ack", ack, 0);
    i2c_stop();
    #(2 * Q);
    watch = 1'b0;
    #20;
    chk("rej_no_drive", bad_seen, 0);

    // START injected at bit 4 of a read byte
    i2c_start();
    wbyte(8'hA0, -1, ack);
    wbyte(8'h10, -1, ack);
    i2c_start();
    wbyte(8'hA1, -1, ack);
    rbyte(d, 1'b1); chk("abort_d0", d, 8'hB5);
    for (int i = 2; i >= 0; i--) begin
      rbit(b);
      part[i] = b;
    end
    chk("abort_partial", part, 3'b101);
    i2c_start();
    chk("abort_sda_rel", sda_oe, 0);
    wbyte(8'hA1, -1, ack); chk("abort_readdr_ack", ack, 1);
    rbyte(d, 1'b0); chk("abort_d_next", d, 8'hB7);
    i2c_stop();
    #(2 * Q);

    // Reset pulsed while the target drives ACK
    i2c_start();
    wbyte(8'hA0, -1, ack);
    for (int i = 7; i >= 0; i--) wbit(((8'h20 >> i) & 8'h01) != 0, 1'b0);
    chk("rstack_driving", sda_oe, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstack_sda_oe", sda_oe, 0);
    chk("rstack_raddr", raddr, 0);
    chk("rstack_active", active, 0);
    #20;
    rst_n = 1'b1;
    #Q;
    i2c_stop();
    #(2 * Q);
    i2c_start();
    wbyte(8'hA1, -1, ack); chk("rstack_recover_ack", ack, 1);
    rbyte(d, 1'b0); chk("rstack_recover_d", d, 8'hA5);
    i2c_stop();
    #(2 * Q);

    // 1-clk SCL low glitch during an address bit
    i2c_start();
    wbyte(8'hA0, 2, ack); chk("glitch_ack", ack, 1);
    wbyte(8'h05, -1, ack); chk("glitch_ofs_ack", ack, 1);
    i2c_start();
    wbyte(8'hA1, -1, ack);
    rbyte(d, 1'b0); chk("glitch_d", d, 8'hA0);
    i2c_stop();
    #(2 * Q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
